// File: rtl/oven_led_pkg.sv
// Shared types for the oven front-panel LED driver: request encodings and FSM states.
package oven_led_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_SLOW  = 3'd2,
        MODE_FAST  = 3'd3,
        MODE_BURST = 3'd4
    } led_mode_e;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ON    = 3'd1,
        ST_SLOW  = 3'd2,
        ST_FAST  = 3'd3,
        ST_BURST = 3'd4
    } led_state_e;

endpackage

// File: rtl/led_phase_timer.sv
// Down-counter shared by all blink/burst states: pulses expire when the count reaches 1,
// then reloads itself with the last loaded value. A count of 0 means idle.
module led_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] reload_q;

    assign expire = (count_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (load) begin
            count_q  <= load_val;
            reload_q <= load_val;
        end else if (expire) begin
            count_q  <= reload_q;
        end else if (count_q != '0) begin
            count_q  <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/oven_led_driver.sv
// Front-panel LED waveform generator: OFF/ON/slow blink/fast blink/counted burst,
// with a registered led output that changes on the accepting edge.
module oven_led_driver
    import oven_led_pkg::*;
#(
    parameter int SLOW_HALF = 50,
    parameter int FAST_HALF = 10,
    parameter int CNT_W     = 16,
    parameter int BURST_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_valid,
    input  logic [MODE_W-1:0]  mode,
    input  logic [BURST_W-1:0] burst_count,
    output logic               mode_ready,
    output logic               led,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    // Handshake: a request transfers on a clk edge where mode_valid && mode_ready;
    // mode and burst_count are sampled on that edge. mode_ready is low only during a
    // burst, and the requester must hold mode_valid (and its payload) until transfer.

    led_state_e         state_q, state_d;
    logic               led_q, led_d;
    logic               done_q, done_d;
    logic [BURST_W-1:0] pulse_q, pulse_d;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic               accept;

    assign mode_ready = (state_q != ST_BURST);
    assign busy       = (state_q == ST_BURST);
    assign led        = led_q;
    assign done       = done_q;
    assign dbg_state  = state_q;
    assign accept     = mode_valid && mode_ready;

    led_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        done_d   = 1'b0;
        pulse_d  = pulse_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            ST_SLOW, ST_FAST: begin
                if (tmr_expire) led_d = ~led_q;
            end
            ST_BURST: begin
                // led_q high = inside a pulse; the pulse counter only moves at the end of a low phase
                if (tmr_expire) begin
                    if (led_q) begin
                        led_d = 1'b0;
                    end else if (pulse_q <= BURST_W'(1)) begin
                        state_d  = ST_OFF;
                        done_d   = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        pulse_d = pulse_q - BURST_W'(1);
                        led_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            tmr_load = 1'b1;
            case (mode)
                MODE_ON: begin
                    state_d = ST_ON;
                    led_d   = 1'b1;
                end
                MODE_SLOW: begin
                    state_d = ST_SLOW;
                    led_d   = 1'b1;
                    tmr_val = CNT_W'(SLOW_HALF);
                end
                MODE_FAST: begin
                    state_d = ST_FAST;
                    led_d   = 1'b1;
                    tmr_val = CNT_W'(FAST_HALF);
                end
                MODE_BURST: begin
                    if (burst_count == '0) begin
                        state_d = ST_OFF;
                        led_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        led_d   = 1'b1;
                        pulse_d = burst_count;
                        tmr_val = CNT_W'(FAST_HALF);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    led_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_OFF;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_oven_led_driver.sv
// Directed bench for oven_led_driver with a cycle-count reference model and literal waveform checks.
module tb_oven_led_driver;
    localparam int SLOW_HALF = 4;
    localparam int FAST_HALF = 2;
    localparam int CNT_W     = 16;
    localparam int BURST_W   = 4;

    logic               clk;
    logic               reset;
    logic               mode_valid;
    logic [2:0]         mode;
    logic [BURST_W-1:0] burst_count;
    logic               mode_ready;
    logic               led;
    logic               busy;
    logic               done;
    logic [2:0]         dbg_state;

    int n_checks;
    int n_fail;

    oven_led_driver #(
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF),
        .CNT_W     (CNT_W),
        .BURST_W   (BURST_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_valid  (mode_valid),
        .mode        (mode),
        .burst_count (burst_count),
        .mode_ready  (mode_ready),
        .led         (led),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // reference model: mode + cycles elapsed since the accepting edge
    int m_mode;
    int m_k;
    int m_n;
    bit m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0;
            m_k    = 0;
            m_n    = 0;
            m_done = 0;
        end else begin
            bit rdy;
            rdy    = (m_mode != 4);
            m_done = 0;
            m_k++;
            if (m_mode == 4 && m_k == 2 * m_n * FAST_HALF) begin
                m_mode = 0;
                m_done = 1;
            end
            if (mode_valid && rdy) begin
                m_k = 0;
                if (mode == 3'd4) begin
                    if (burst_count == 0) begin
                        m_mode = 0;
                        m_done = 1;
                    end else begin
                        m_mode = 4;
                        m_n    = int'(burst_count);
                    end
                end else if (mode >= 3'd1 && mode <= 3'd3) begin
                    m_mode = int'(mode);
                end else begin
                    m_mode = 0;
                end
            end
        end
    end

    function automatic logic exp_led();
        case (m_mode)
            1: return 1'b1;
            2: return ((m_k / SLOW_HALF) % 2) == 0;
            3, 4: return ((m_k / FAST_HALF) % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // compare process
    always @(negedge clk) begin
        if (!reset) begin
            check("model_led",   led,        exp_led());
            check("model_ready", mode_ready, m_mode != 4);
            check("model_busy",  busy,       m_mode == 4);
            check("model_done",  done,       m_done);
        end
    end

    // driver tasks
    task automatic req(input logic [2:0] m, input logic [BURST_W-1:0] bc);
        logic rdy;
        int   cnt;
        @(negedge clk);
        mode_valid  = 1'b1;
        mode        = m;
        burst_count = bc;
        cnt = 0;
        do begin
            rdy = mode_ready;
            @(negedge clk);
            cnt++;
        end while (!rdy && cnt < 100);
        if (!rdy) check("req_timeout", 32'd0, 32'd1);
        mode_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [8:0]  slow_pat;
        logic [11:0] burst_pat;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        mode_valid  = 1'b0;
        mode        = 3'd0;
        burst_count = '0;
        #1;
        check("rst_led",   led,        1'b0);
        check("rst_ready", mode_ready, 1'b1);
        check("rst_busy",  busy,       1'b0);
        check("rst_done",  done,       1'b0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // ON then OFF 5 cycles later
        req(3'd1, '0);
        check("on_led", led, 1'b1);
        idle(4);
        req(3'd0, '0);
        check("off_led", led, 1'b0);
        idle(3);

        // SLOW pattern, listed from k=0 upward
        slow_pat = 9'b1_0000_1111;
        req(3'd2, '0);
        for (int i = 0; i < 9; i++) begin
            check("slow_pat", led, slow_pat[i]);
            @(negedge clk);
        end
        idle(4);
        check("slow_low_before_restart", led, 1'b0);
        req(3'd2, '0);
        for (int i = 0; i < 4; i++) begin
            check("slow_restart_high", led, 1'b1);
            @(negedge clk);
        end
        check("slow_restart_low", led, 1'b0);

        // BURST N=3 with FAST held pending
        burst_pat = 12'b0011_0011_0011;
        req(3'd4, 4'd3);
        mode_valid = 1'b1;
        mode       = 3'd3;
        for (int i = 0; i < 12; i++) begin
            check("burst_led",   led,        burst_pat[i]);
            check("burst_busy",  busy,       1'b1);
            check("burst_ready", mode_ready, 1'b0);
            check("burst_done",  done,       1'b0);
            @(negedge clk);
        end
        check("burst_end_done",  done,       1'b1);
        check("burst_end_led",   led,        1'b0);
        check("burst_end_ready", mode_ready, 1'b1);
        check("burst_end_busy",  busy,       1'b0);
        @(negedge clk);
        mode_valid = 1'b0;
        check("fast_after_done_led",  led,  1'b1);
        check("fast_after_done_done", done, 1'b0);
        idle(7);

        // BURST N=0 and a reserved mode
        req(3'd4, 4'd0);
        check("burst0_done", done, 1'b1);
        check("burst0_led",  led,  1'b0);
        check("burst0_busy", busy, 1'b0);
        @(negedge clk);
        check("burst0_done_clear", done, 1'b0);
        req(3'd1, '0);
        idle(2);
        req(3'd6, '0);
        check("reserved_led",  led,       1'b0);
        check("reserved_dbg",  dbg_state, 3'd0);
        idle(3);

        // asynchronous reset in the middle of a SLOW blink
        req(3'd2, '0);
        idle(1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_led",   led,        1'b0);
        check("async_rst_ready", mode_ready, 1'b1);
        check("async_rst_busy",  busy,       1'b0);
        idle(2);
        reset = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
